// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S encodings, receiver state type and length decode
package i2s_pkg;

  // Data length select encodings
  localparam logic [1:0] I2S_DAL_8_BITS  = 2'b00;
  localparam logic [1:0] I2S_DAL_16_BITS = 2'b01;
  localparam logic [1:0] I2S_DAL_24_BITS = 2'b10;
  localparam logic [1:0] I2S_DAL_32_BITS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2
  } rx_state_e;

  // Number of payload bits kept per word for a given length select
  function automatic logic [5:0] dal2len(input logic [1:0] dal);
    logic [5:0] len;
    case (dal)
      I2S_DAL_8_BITS:  len = 6'd8;
      I2S_DAL_16_BITS: len = 6'd16;
      I2S_DAL_24_BITS: len = 6'd24;
      I2S_DAL_32_BITS: len = 6'd32;
      default:         len = 6'd32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - multi-flop synchronizer with rising-edge detect
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next state of the synchronizer chain and the one-cycle-delayed copy
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Register the chain; everything cleared on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S target receiver, Philips format; I2S_RX_LJ_EN selects left-justified
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            dal_i,
  input  logic                  i2s_sck_i,
  input  logic                  i2s_ws_i,
  input  logic                  i2s_sd_i,
  output logic                  smp_valid_o,
  input  logic                  smp_ready_i,
  output logic [DATA_WIDTH-1:0] smp_data_o,
  output logic                  smp_chl_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i,
  output logic                  busy_o
);

  logic sck_s, sck_rise, ws_s, ws_rise_unused;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic sd_s;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (i2s_sck_i),
    .sync_o  (sck_s),
    .rise_o  (sck_rise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ws_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (i2s_ws_i),
    .sync_o  (ws_s),
    .rise_o  (ws_rise_unused)
  );

  // Serial data only needs the same delay as sck/ws, no edge detect
  always_comb sd_sync_d = {sd_sync_q[SYNC_STAGES-2:0], i2s_sd_i};
  assign sd_s = sd_sync_q[SYNC_STAGES-1];

  // Receive state, shift register and the one-cycle emit stage
  rx_state_e             state_q, state_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  chl_q, chl_d;
  logic                  ws_last_q, ws_last_d;
  logic                  emit_q, emit_d;
  logic [DATA_WIDTH-1:0] emit_data_q, emit_data_d;
  logic                  emit_chl_q, emit_chl_d;

  // Output register and sticky overrun
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  out_chl_q, out_chl_d;
  logic                  ovf_q, ovf_d;

  logic                  ws_chg;
  logic                  new_chl;
  logic [5:0]            len;
  logic [DATA_WIDTH-1:0] sh_f;
  logic [5:0]            cnt_f;
  logic                  drop;

  assign ws_chg = sck_s & (ws_s != ws_last_q);
  assign len    = dal2len(dal_i);

`ifdef I2S_RX_LJ_EN
  assign new_chl = ~ws_s;
`else
  assign new_chl = ws_s;
`endif

  // Framing FSM: align on the first WS change, shift MSB-first, emit on every later WS change
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    chl_d       = chl_q;
    ws_last_d   = sck_rise ? ws_s : ws_last_q;
    emit_d      = 1'b0;
    emit_data_d = emit_data_q;
    emit_chl_d  = emit_chl_q;
    sh_f        = shreg_q;
    cnt_f       = bit_cnt_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (en_i) state_d = ALIGN;
      end
      ALIGN: begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (sck_rise && ws_chg) begin
          state_d = SHIFT;
          chl_d   = new_chl;
`ifdef I2S_RX_LJ_EN
          // The MSB arrives together with the WS change
          bit_cnt_d = 6'd1;
          shreg_d   = {{(DATA_WIDTH-1){1'b0}}, sd_s};
`endif
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          if (!ws_chg) begin
            if (bit_cnt_q < len) begin
              shreg_d   = {shreg_q[DATA_WIDTH-2:0], sd_s};
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end else begin
`ifndef I2S_RX_LJ_EN
            // One-bit delay: this bit is still the LSB of the word being closed
            if (bit_cnt_q < len) begin
              sh_f  = {shreg_q[DATA_WIDTH-2:0], sd_s};
              cnt_f = bit_cnt_q + 6'd1;
            end
`endif
            emit_d      = 1'b1;
            emit_data_d = sh_f << (len - cnt_f);
            emit_chl_d  = chl_q;
            chl_d       = new_chl;
`ifdef I2S_RX_LJ_EN
            bit_cnt_d = 6'd1;
            shreg_d   = {{(DATA_WIDTH-1){1'b0}}, sd_s};
`else
            bit_cnt_d = '0;
            shreg_d   = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts any word in progress; an emit already registered still lands
    if (!en_i) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      emit_d    = 1'b0;
    end
  end

  // Output holding register: accept when empty or draining, otherwise drop and flag overrun
  always_comb begin
    valid_d   = valid_q & ~smp_ready_i;
    data_d    = data_q;
    out_chl_d = out_chl_q;
    drop      = 1'b0;
    if (emit_q) begin
      if (!valid_q || smp_ready_i) begin
        valid_d   = 1'b1;
        data_d    = emit_data_q;
        out_chl_d = emit_chl_q;
      end else begin
        drop = 1'b1;
      end
    end
    ovf_d = drop | (ovf_q & ~ovf_clr_i);
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sd_sync_q   <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      chl_q       <= 1'b0;
      ws_last_q   <= 1'b0;
      emit_q      <= 1'b0;
      emit_data_q <= '0;
      emit_chl_q  <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      out_chl_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sd_sync_q   <= sd_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      chl_q       <= chl_d;
      ws_last_q   <= ws_last_d;
      emit_q      <= emit_d;
      emit_data_q <= emit_data_d;
      emit_chl_q  <= emit_chl_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      out_chl_q   <= out_chl_d;
      ovf_q       <= ovf_d;
    end
  end

  assign smp_valid_o = valid_q;
  assign smp_data_o  = data_q;
  assign smp_chl_o   = out_chl_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Serial-to-parallel I2S receiver: the target/codec-facing receive end of the I2S link.
- Oversamples external SCK/WS/SD in the system clock domain and assembles MSB-first serial words into 32-bit samples tagged with channel.
- Presents samples on a valid/ready stream toward an RX FIFO or register block.
- Works in target mode: SCK and WS are driven by the link controller.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on i2s_sck_i/i2s_ws_i/i2s_sd_i (min 2).
- DATA_WIDTH, 32, output sample width (fixed 32 in this revision).

Ports:
- clk_i  in  1  system clock; must be >= 4x SCK frequency.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  receiver enable.
- dal_i  in  2  data length: 00=8, 01=16, 10=24, 11=32 bits.
- i2s_sck_i  in  1  async serial clock.
- i2s_ws_i  in  1  async word select.
- i2s_sd_i  in  1  async serial data.
- smp_valid_o  out  1  sample available.
- smp_ready_i  in  1  consumer accepts sample.
- smp_data_o  out  32  sample, right-aligned, zero-extended.
- smp_chl_o  out  1  0=left, 1=right.
- ovf_o  out  1  sticky overrun flag.
- ovf_clr_i  in  1  clears ovf_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift register, bit count and synchronizers cleared.
- Sync and edge detect:
  - Each input passes through SYNC_STAGES flops.
  - sck_rise = synced sck & ~sck_prev. All sampling happens only on sck_rise cycles.
  - ws_chg = (synced ws != ws_last), evaluated on sck_rise. ws_last updates on every sck_rise.
- FSM:
  - IDLE: entered on reset or when en_i=0. When en_i=1, go to ALIGN.
  - ALIGN: discard data until the first ws_chg, then go to SHIFT with bit_cnt=0 and chl latched from ws. This means no partial word is ever emitted after enable.
  - SHIFT, sck_rise without ws_chg: if bit_cnt < len, shift sd in at the LSB and increment bit_cnt. Extra bits beyond len are ignored.
  - SHIFT, sck_rise with ws_chg: first shift the current sd bit if bit_cnt < len (this is the previous word's LSB in Philips timing). Then emit the word, clear bit_cnt and shreg, latch the new chl, and stay in SHIFT.
- Philips timing: the MSB is sampled on the sck_rise after the ws_chg edge. Channel is latched as chl = ws (ws low = left).
- Short word (bits received < len at emit): left-justify within len, i.e. data = shreg << (len - cnt), so the MSB position is correct and the low bits are 0.
- Emit and output register:
  - If smp_valid_o=0, or smp_valid_o & smp_ready_i in the same cycle: load smp_data_o/smp_chl_o and set smp_valid_o on the next clk.
  - Else (holding an unaccepted sample): drop the new word, keep the held sample unchanged, set ovf_o.
- Handshake:
  - Transfer occurs when smp_valid_o & smp_ready_i. smp_valid_o clears the next cycle unless a new emit coincides.
  - smp_data_o and smp_chl_o are stable while valid and not ready.
- Latency: pin WS/SD edge -> smp_valid_o = SYNC_STAGES + 2 clk_i cycles.
- ovf_o: set on drop, cleared by ovf_clr_i. If both occur in the same cycle, set wins.
- en_i deassert mid-word: next cycle go to IDLE and discard shreg/bit_cnt. A pending output sample stays valid until accepted.
- dal_i change is sampled only at emit time. Software must change it only while en_i=0.

Optional Feature:
- Macro: I2S_RX_LJ_EN.
- Defined: left-justified format. MSB is sampled on the same sck_rise as ws_chg: emit the old word without shifting, then shift the current bit as new bit 0 (bit_cnt=1). Channel is latched as chl = ~ws (ws high = left).
- Undefined: Philips one-bit-delay format only, as above.

Decomposition:
- Shared package i2s_pkg:
  - DAL encodings I2S_DAL_8/16/24/32_BITS, reused by the existing control logic.
  - Typedef rx_state_e {IDLE, ALIGN, SHIFT}.
  - Function dal2len() returning 6-bit length.
- Sub-module i2s_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect. Instantiate once each for sck and ws; sd is synchronize-only.

Test Plan:
- Philips, dal=01: send L=0xA5C3, R=0x1234 at clk/8 SCK -> two beats {chl=0, data=0x0000A5C3} then {chl=1, data=0x00001234}, each SYNC_STAGES+2 clk after the WS edge.
- dal=00 with 16-bit frames carrying 0xBEEF -> data=0x000000BE (extra bits ignored). dal=11, 32-bit 0xDEADBEEF -> 0xDEADBEEF.
- Hold smp_ready_i=0 over three words -> first sample held unchanged, ovf_o=1, remaining two dropped. ovf_clr_i pulse -> ovf_o=0.
- Enable mid-frame (assert en_i halfway through a left word) -> no emit until the next WS change. The first beat is the right channel.
- Drop en_i after 5 bits of a 16-bit word -> busy_o=0 next cycle, no sample emitted. Re-enable -> realigns, next full word correct.
- With I2S_RX_LJ_EN: LJ 24-bit 0x7FFFFF on WS high -> {chl=0, data=0x007FFFFF}.
